// File: rtl/ras_jr_predictor_pkg.sv
// Shared constants and types for the return-address-stack jr predictor.
// RA_REG is the link register index, also used by the instruction decoder.
package ras_jr_predictor_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;
  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_e;

  // A jal that is also a jr $31 swaps the top entry instead of push+pop.
  function automatic stack_op_e decode_op(input logic jal, input logic jr_ra);
    case ({jal, jr_ra})
      2'b10:   decode_op = OP_PUSH;
      2'b01:   decode_op = OP_POP;
      2'b11:   decode_op = OP_REPLACE;
      default: decode_op = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ras_stack_mem.sv
// DEPTH x WIDTH register array for the return-address stack.
// The top entry is read asynchronously; a single synchronous write port.
module ras_stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_jr_predictor.sv
// Circular return-address stack: jal pushes in D, jr $31 pops and predicts,
// X checks the carried prediction against the resolved target and redirects.
module ras_jr_predictor
  import ras_jr_predictor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   squash,
  input  logic                   d_jal,
  input  logic                   d_jr_ra,
  input  logic [WIDTH-1:0]       d_link_addr,
  output logic                   pred_valid,
  output logic [WIDTH-1:0]       pred_target,
  input  logic                   x_jr_resolve,
  input  logic [WIDTH-1:0]       x_jr_target,
  output logic                   mispredict,
  output logic [WIDTH-1:0]       redirect_pc,
  output logic [$clog2(DEPTH):0] depth_used,
  output logic [CNT_W-1:0]       mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;
  logic             x_pv;
  logic [WIDTH-1:0] x_pt;
  logic [WIDTH-1:0] top_data;
  logic             empty;
  logic             upd;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  stack_op_e        op;

  ras_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (d_link_addr),
    .raddr (ptr),
    .rdata (top_data)
  );

  assign empty       = (count == '0);
  assign op          = decode_op(d_jal, d_jr_ra);
  assign pred_valid  = d_jr_ra & ~empty;
  assign pred_target = empty ? '0 : top_data;

  // Gated by reset so a resolve arriving during reset cannot leak a redirect.
  assign mispredict  = ~reset & x_jr_resolve & (~x_pv | (x_pt != x_jr_target));
  assign redirect_pc = mispredict ? x_jr_target : '0;
  assign upd         = ~stall & ~squash & ~mispredict;
  assign depth_used  = count;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    if (upd) begin
      case (op)
        OP_PUSH: begin
          mem_we    = 1'b1;
          mem_waddr = ptr + PTR_ONE;
        end
        OP_REPLACE: mem_we = 1'b1;
        default: ;
      endcase
    end
  end

  // A mispredict flushes the stack contents but keeps the pointer position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (mispredict) begin
      count <= '0;
    end else if (upd) begin
      case (op)
        OP_PUSH: begin
          ptr <= ptr + PTR_ONE;
          if (count != FULL) count <= count + CNT_ONE;
        end
        OP_POP: begin
          if (!empty) begin
            ptr   <= ptr - PTR_ONE;
            count <= count - CNT_ONE;
          end
        end
        OP_REPLACE: begin
          if (empty) count <= CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_pv <= 1'b0;
      x_pt <= '0;
    end else if (upd) begin
      x_pv <= pred_valid;
      x_pt <= pred_target;
    end else begin
      x_pv <= 1'b0;
      x_pt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mispredict_cnt <= '0;
    end else if (mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ras_jr_predictor.sv
// Directed, table-driven bench for ras_jr_predictor with DEPTH=8, WIDTH=32,
// plus hand-written overflow and async-reset sequences.
module tb_ras_jr_predictor;
  import ras_jr_predictor_pkg::*;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        squash;
  logic        d_jal;
  logic        d_jr_ra;
  logic [31:0] d_link_addr;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        x_jr_resolve;
  logic [31:0] x_jr_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  depth_used;
  logic [15:0] mispredict_cnt;

  int total;
  int bad;

  typedef struct {
    logic        stall;
    logic        squash;
    logic        jal;
    logic        jr;
    logic [31:0] link;
    logic        res;
    logic [31:0] xt;
    logic        e_pv;
    logic [31:0] e_pt;
    logic        e_mp;
    logic [31:0] e_rpc;
    int          e_depth;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  ras_jr_predictor #(
    .WIDTH (32),
    .DEPTH (8),
    .CNT_W (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .squash         (squash),
    .d_jal          (d_jal),
    .d_jr_ra        (d_jr_ra),
    .d_link_addr    (d_link_addr),
    .pred_valid     (pred_valid),
    .pred_target    (pred_target),
    .x_jr_resolve   (x_jr_resolve),
    .x_jr_target    (x_jr_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .depth_used     (depth_used),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic st, input logic sq, input logic jal,
                              input logic jr, input logic [31:0] link,
                              input logic res, input logic [31:0] xt,
                              input logic pv, input logic [31:0] pt,
                              input logic mp, input logic [31:0] rpc,
                              input int dep, input int cnt);
    vec_t v;
    v.stall = st; v.squash = sq; v.jal = jal; v.jr = jr; v.link = link;
    v.res = res; v.xt = xt; v.e_pv = pv; v.e_pt = pt; v.e_mp = mp;
    v.e_rpc = rpc; v.e_depth = dep; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic sq, input logic jal,
                                input logic jr, input logic [31:0] link,
                                input logic res, input logic [31:0] xt);
    stall = st; squash = sq; d_jal = jal; d_jr_ra = jr; d_link_addr = link;
    x_jr_resolve = res; x_jr_target = xt;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    $display("[TB] start, link register index %0d", RA_REG);

    // Stimulus table: st sq jal jr link res xt | pv pt mp rpc depth cnt
    tbl.push_back(mk(0,0,1,0,32'h100,0,32'h0,   0,32'h0,  0,32'h0,  1,0));
    tbl.push_back(mk(0,0,1,0,32'h200,0,32'h0,   0,32'h100,0,32'h0,  2,0));
    tbl.push_back(mk(0,0,0,1,32'h0,  0,32'h0,   1,32'h200,0,32'h0,  1,0));
    tbl.push_back(mk(0,0,0,1,32'h0,  1,32'h200, 1,32'h100,0,32'h0,  0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,  1,32'h100, 0,32'h0,  0,32'h0,  0,0));
    tbl.push_back(mk(0,0,0,1,32'h0,  0,32'h0,   0,32'h0,  0,32'h0,  0,0));
    tbl.push_back(mk(0,0,0,0,32'h0,  1,32'h40,  0,32'h0,  1,32'h40, 0,1));
    tbl.push_back(mk(1,0,1,0,32'h300,0,32'h0,   0,32'h0,  0,32'h0,  0,1));
    tbl.push_back(mk(0,1,1,0,32'h300,0,32'h0,   0,32'h0,  0,32'h0,  0,1));
    tbl.push_back(mk(0,0,0,0,32'h0,  1,32'h300, 0,32'h0,  1,32'h300,0,2));
    tbl.push_back(mk(0,0,1,0,32'h500,0,32'h0,   0,32'h0,  0,32'h0,  1,2));
    tbl.push_back(mk(0,0,1,0,32'h600,0,32'h0,   0,32'h500,0,32'h0,  2,2));
    tbl.push_back(mk(0,0,0,1,32'h0,  0,32'h0,   1,32'h600,0,32'h0,  1,2));
    tbl.push_back(mk(0,0,1,0,32'h800,1,32'h700, 0,32'h500,1,32'h700,0,3));
    tbl.push_back(mk(0,0,0,1,32'h0,  0,32'h0,   0,32'h0,  0,32'h0,  0,3));
    tbl.push_back(mk(0,0,1,0,32'hA0, 0,32'h0,   0,32'h0,  0,32'h0,  1,3));
    tbl.push_back(mk(0,0,1,1,32'hB0, 0,32'h0,   1,32'hA0, 0,32'h0,  1,3));
    tbl.push_back(mk(0,0,0,1,32'h0,  1,32'hA0,  1,32'hB0, 0,32'h0,  0,3));
    tbl.push_back(mk(0,0,0,0,32'h0,  1,32'hB0,  0,32'h0,  0,32'h0,  0,3));
    tbl.push_back(mk(0,0,1,1,32'hC0, 0,32'h0,   0,32'h0,  0,32'h0,  1,3));
    tbl.push_back(mk(0,0,0,1,32'h0,  0,32'h0,   1,32'hC0, 0,32'h0,  0,3));
    tbl.push_back(mk(0,0,0,0,32'h0,  1,32'hC1,  0,32'h0,  1,32'hC1, 0,4));

    #12;
    check_output("reset_pred_target", pred_target, 32'h0);
    check_output("reset_depth", {28'h0, depth_used}, 32'h0);
    check_output("reset_cnt", {16'h0, mispredict_cnt}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i].stall, tbl[i].squash, tbl[i].jal, tbl[i].jr,
                     tbl[i].link, tbl[i].res, tbl[i].xt);
      #3;
      check_output($sformatf("v%0d_pred_valid", i), {31'h0, pred_valid}, {31'h0, tbl[i].e_pv});
      check_output($sformatf("v%0d_pred_target", i), pred_target, tbl[i].e_pt);
      check_output($sformatf("v%0d_mispredict", i), {31'h0, mispredict}, {31'h0, tbl[i].e_mp});
      check_output($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
      @(posedge clock);
      #1;
      check_output($sformatf("v%0d_depth", i), {28'h0, depth_used}, 32'(tbl[i].e_depth));
      check_output($sformatf("v%0d_cnt", i), {16'h0, mispredict_cnt}, 32'(tbl[i].e_cnt));
    end

    // Overflow: nine pushes into an 8-deep stack lose the oldest entry.
    for (int i = 1; i <= 9; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'(i), 1'b0, 32'h0);
      @(posedge clock);
      #1;
      check_output($sformatf("ovf_push%0d_depth", i), {28'h0, depth_used},
                   (i > 8) ? 32'd8 : 32'(i));
    end
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
      #3;
      check_output($sformatf("ovf_pop%0d_valid", k), {31'h0, pred_valid}, 32'h1);
      check_output($sformatf("ovf_pop%0d_target", k), pred_target, 32'(9 - k));
      @(posedge clock);
      #1;
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    #3;
    check_output("ovf_pop9_valid", {31'h0, pred_valid}, 32'h0);
    @(posedge clock);
    #1;
    check_output("ovf_pop9_depth", {28'h0, depth_used}, 32'h0);

    // Async reset between edges must clear everything immediately.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hD0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hE0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    check_output("prereset_depth", {28'h0, depth_used}, 32'h2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h55);
    #2;
    reset = 1'b1;
    #1;
    check_output("areset_pred_valid", {31'h0, pred_valid}, 32'h0);
    check_output("areset_pred_target", pred_target, 32'h0);
    check_output("areset_mispredict", {31'h0, mispredict}, 32'h0);
    check_output("areset_redirect_pc", redirect_pc, 32'h0);
    check_output("areset_depth", {28'h0, depth_used}, 32'h0);
    check_output("areset_cnt", {16'h0, mispredict_cnt}, 32'h0);
    @(negedge clock);
    idle();
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hF0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    #3;
    check_output("postreset_valid", {31'h0, pred_valid}, 32'h1);
    check_output("postreset_target", pred_target, 32'hF0);
    @(posedge clock);
    #1;
    check_output("postreset_depth", {28'h0, depth_used}, 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ras_jr_predictor.md
Name: ras_jr_predictor

Overview:
- Parametrised successor to the single-entry jal→jr target bypass.
- Implements a DEPTH-entry circular return-address stack for the 5-stage CPU.
- Decode stage (D):
  - jal pushes its link address.
  - jr $31 pops the stack and gets a predicted target without waiting for writeback.
- Execute stage (X): compares the carried prediction against the resolved jr target and raises a redirect on mismatch.

Parameters:
- WIDTH, 32, address/PC width in bits.
- DEPTH, 8, stack entries; must be a power of 2 and at least 2.
- PTR_W, $clog2(DEPTH), derived localparam; not overridable.
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  D stage held; no stack update; X receives a bubble.
- squash  in  1  D instruction is wrong-path; no stack update; X receives a bubble.
- d_jal  in  1  D instruction is jal (push).
- d_jr_ra  in  1  D instruction is jr $31 (pop and predict).
- d_link_addr  in  WIDTH  return address pushed by jal (PC+1 of the jal).
- pred_valid  out  1  combinational; d_jr_ra and stack non-empty.
- pred_target  out  WIDTH  combinational; top-of-stack entry; 0 when the stack is empty.
- x_jr_resolve  in  1  jr $31 is in X this cycle with its resolved target.
- x_jr_target  in  WIDTH  architecturally correct jr target.
- mispredict  out  1  combinational X redirect request.
- redirect_pc  out  WIDTH  equals x_jr_target whenever mispredict=1, otherwise 0.
- depth_used  out  PTR_W+1  current entry count, 0..DEPTH.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Reset (async, active-high):
  - top pointer and count are 0.
  - All stack entries are 0.
  - X pipe register is cleared (x_pv=0, x_pt=0).
  - mispredict_cnt is 0.
  - Every output is 0 while reset is held.
  - Reset asserted mid-operation discards all state immediately.
- D update enable:
  - upd = !stall & !squash & !mispredict.
  - mispredict overrides every D update that cycle.
- Push (upd & d_jal & !d_jr_ra):
  - ptr <= ptr+1 (mod DEPTH).
  - mem[ptr+1] <= d_link_addr.
  - count <= min(count+1, DEPTH).
  - Full push overwrites the oldest entry via wrap-around; count stays DEPTH.
- Pop (upd & d_jr_ra & !d_jal):
  - If count>0: ptr <= ptr-1 (mod DEPTH), count <= count-1.
  - If empty: no change; pred_valid=0.
- Both asserted (upd & d_jal & d_jr_ra):
  - Replace top: mem[ptr] <= d_link_addr.
  - If count was 0, count <= 1.
  - Prediction uses the old top.
- Push-then-pop in adjacent cycles: jr in cycle n+1 sees the link pushed in cycle n; no extra bypass is needed.
- X pipe register (carries pred_valid and pred_target into x_pv and x_pt):
  - On upd: latched from D.
  - On stall, squash, or mispredict: cleared to 0 (bubble).
- Mispredict:
  - mispredict = x_jr_resolve & (!x_pv | x_pt != x_jr_target).
  - Combinational, same cycle as resolution.
  - At the next edge: count <= 0, ptr unchanged (stack flushed).
  - mispredict_cnt increments and saturates at 2^CNT_W-1.
- Correct prediction (x_jr_resolve & x_pv & match): no state change beyond the normal D update.
- All arithmetic is unsigned.
- Pointer wrap is implicit through the PTR_W-bit width.

Decomposition:
- Shared cpu_pkg (or `include defines) holds:
  - Default WIDTH and DEPTH constants.
  - Register index 31 (RA) constant, shared with the instruction decoder.
- Natural sub-module: ras_stack_mem.
  - DEPTH×WIDTH register array.
  - Async read of the top entry; synchronous write port.
  - Async clear on reset.
- Top level holds:
  - Pointer and count logic.
  - X pipe register.
  - Compare and counter logic.
- d_jal and d_jr_ra come from the existing instruction_decoder instantiated by the pipeline, not inside this block.

Test Plan:
1. Basic push/pop:
   - Reset; push 0x100, 0x200; then d_jr_ra.
   - pred_valid=1, pred_target=0x200, depth_used=1 after the edge.
   - Next d_jr_ra predicts 0x100.
2. Empty pop:
   - After reset, d_jr_ra=1.
   - pred_valid=0, pred_target=0, depth_used stays 0.
   - x_jr_resolve next cycle with target 0x40 gives mispredict=1, redirect_pc=0x40, mispredict_cnt=1.
3. Overflow wrap (DEPTH=8):
   - Push 0x1..0x9 (9 pushes) → depth_used=8.
   - Eight pops predict 0x9 down to 0x2.
   - Ninth pop gives pred_valid=0.
4. Stall/squash gating:
   - Push 0x300 with stall=1 → depth_used stays 0.
   - Push 0x300 with squash=1 → no change, and X sees x_pv=0.
5. Mispredict flush:
   - Push 0x500, 0x600; pop (predict 0x600).
   - Resolve with 0x700 → mispredict=1 that cycle.
   - Next cycle depth_used=0; a push asserted in the mispredict cycle is ignored.
6. Simultaneous jal+jr and async reset:
   - With stack [0xA0], assert both → pred_target=0xA0, top becomes link 0xB0, depth_used=1.
   - Assert reset between clock edges → all outputs 0 immediately.
